// File: rtl/result_demux.sv
// result_demux: routes 32-bit results to two independently buffered ports.
// Define RESULT_DEMUX_SKID_EN for 2-deep stores and a registered in_ready.
module result_demux (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_sel,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] a_data,
  output logic        a_valid,
  input  logic        a_ready,
  output logic [31:0] b_data,
  output logic        b_valid,
  input  logic        b_ready
);
  // Index 0 is port A, index 1 is port B.
  logic [1:0]  x_ready;
  logic [1:0]  push;
  logic [1:0]  pop;
  logic        sel_idx;
  logic [31:0] head_q [2];
  logic [31:0] head_d [2];

  assign x_ready = {b_ready, a_ready};
  assign sel_idx = ~in_sel;

`ifdef RESULT_DEMUX_SKID_EN
  logic [1:0]  cnt_q [2];
  logic [1:0]  cnt_d [2];
  logic [31:0] tail_q [2];
  logic [31:0] tail_d [2];
  logic [1:0]  vld;

  always_comb begin
    in_ready = ~reset && (cnt_q[sel_idx] != 2'd2);
    for (int p = 0; p < 2; p++) begin
      vld[p]    = cnt_q[p] != 2'd0;
      pop[p]    = vld[p] && x_ready[p];
      push[p]   = in_valid && in_ready
                  && (in_sel == (p == 0));
      cnt_d[p]  = cnt_q[p];
      head_d[p] = head_q[p];
      tail_d[p] = tail_q[p];
      case (cnt_q[p])
        2'd0: begin
          if (push[p]) begin
            head_d[p] = in_data;
            cnt_d[p]  = 2'd1;
          end
        end
        2'd1: begin
          if (push[p] && pop[p]) begin
            head_d[p] = in_data;
          end else if (push[p]) begin
            tail_d[p] = in_data;
            cnt_d[p]  = 2'd2;
          end else if (pop[p]) begin
            cnt_d[p]  = 2'd0;
          end
        end
        default: begin
          // Full: in_ready is low, so only a pop can happen.
          if (pop[p]) begin
            head_d[p] = tail_q[p];
            cnt_d[p]  = 2'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        cnt_q[p]  <= 2'd0;
        head_q[p] <= 32'd0;
        tail_q[p] <= 32'd0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        cnt_q[p]  <= cnt_d[p];
        head_q[p] <= head_d[p];
        tail_q[p] <= tail_d[p];
      end
    end
  end

  assign a_valid = vld[0];
  assign b_valid = vld[1];
`else
  logic [1:0] vld_q;
  logic [1:0] vld_d;

  always_comb begin
    in_ready = ~reset
               && (~vld_q[sel_idx] || x_ready[sel_idx]);
    for (int p = 0; p < 2; p++) begin
      pop[p]    = vld_q[p] && x_ready[p];
      push[p]   = in_valid && in_ready
                  && (in_sel == (p == 0));
      vld_d[p]  = push[p] || (vld_q[p] && ~pop[p]);
      head_d[p] = push[p] ? in_data : head_q[p];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 2'b00;
      for (int p = 0; p < 2; p++) begin
        head_q[p] <= 32'd0;
      end
    end else begin
      vld_q <= vld_d;
      for (int p = 0; p < 2; p++) begin
        head_q[p] <= head_d[p];
      end
    end
  end

  assign a_valid = vld_q[0];
  assign b_valid = vld_q[1];
`endif

  assign a_data = head_q[0];
  assign b_data = head_q[1];

endmodule

// File: tb/tb_result_demux.sv
// tb_result_demux: scoreboard bench for result_demux.
// Build with or without RESULT_DEMUX_SKID_EN to match the RTL.
module tb_result_demux;
  logic        clk;
  logic        reset;
  logic [31:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_data;
  logic        a_valid;
  logic        a_ready;
  logic [31:0] b_data;
  logic        b_valid;
  logic        b_ready;

  result_demux dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Words accepted but not yet consumed, per port.
  logic [31:0] qa [$];
  logic [31:0] qb [$];
  logic [31:0] last_a = 32'd0;
  logic [31:0] last_b = 32'd0;

  task automatic check1(input string name,
                        input logic act,
                        input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // A word may enter a port whose store has room for it this edge.
  function automatic logic exp_rdy(input logic s,
                                   input logic ar,
                                   input logic br);
    int  n;
    logic xr;
    n  = s ? qa.size() : qb.size();
    xr = s ? ar : br;
`ifdef RESULT_DEMUX_SKID_EN
    exp_rdy = (n < 2);
`else
    exp_rdy = (n == 0) || xr;
`endif
  endfunction

  // Monitor: mid-cycle, compare DUT against the model, then retire
  // whatever the consumer takes at the coming edge.
  always @(negedge clk) begin
    if (reset) begin
      check1("in_ready_rst", in_ready, 1'b0);
    end else begin
      check1("in_ready", in_ready,
             exp_rdy(in_sel, a_ready, b_ready));
      check1("a_valid", a_valid, qa.size() != 0);
      check32("a_data", a_data,
              qa.size() != 0 ? qa[0] : last_a);
      check1("b_valid", b_valid, qb.size() != 0);
      check32("b_data", b_data,
              qb.size() != 0 ? qb[0] : last_b);
      if (qa.size() != 0 && a_ready)
        void'(qa.pop_front());
      if (qb.size() != 0 && b_ready)
        void'(qb.pop_front());
    end
  end

  // One cycle of stimulus; the expected word is queued on acceptance.
  task automatic cyc(input logic v, input logic s,
                     input logic [31:0] d,
                     input logic ar, input logic br,
                     input logic rst, output logic acc);
    @(posedge clk);
    #1;
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    a_ready  = ar;
    b_ready  = br;
    reset    = rst;
    acc      = !rst && v && exp_rdy(s, ar, br);
    @(negedge clk);
    #2;
    if (rst) begin
      qa.delete();
      qb.delete();
      last_a = 32'd0;
      last_b = 32'd0;
    end else if (acc) begin
      if (s) begin
        qa.push_back(d);
        last_a = d;
      end else begin
        qb.push_back(d);
        last_b = d;
      end
    end
  endtask

  initial begin
    logic        acc;
    logic [31:0] w;
    int          words;
    int          ncyc;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_sel   = 1'b0;
    in_data  = 32'd0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;

    cyc(0, 0, 0, 0, 0, 1, acc);
    cyc(0, 0, 0, 0, 0, 1, acc);
    cyc(0, 0, 0, 1, 1, 0, acc);

    // Routing
    cyc(1, 1, 32'h1, 1, 1, 0, acc);
    cyc(1, 0, 32'h2, 1, 1, 0, acc);
    cyc(0, 0, 0, 1, 1, 0, acc);
    cyc(0, 0, 0, 1, 1, 0, acc);

    // Stall isolation on A
    cyc(1, 1, 32'hAAAA_0000, 0, 1, 0, acc);
    cyc(1, 0, 32'hBBBB_0000, 0, 1, 0, acc);
    cyc(1, 1, 32'hCCCC_0000, 0, 1, 0, acc);
    cyc(1, 1, 32'hDDDD_0000, 0, 1, 0, acc);
    cyc(0, 0, 0, 0, 1, 0, acc);
    for (int i = 0; i < 4; i++)
      cyc(0, 0, 0, 1, 1, 0, acc);

    // Skid fill: hold each word until taken, raise a_ready late
    w = 32'h21;
    for (int i = 0; i < 14 && w <= 32'h23; i++) begin
      cyc(1, 1, w, i >= 4, 1, 0, acc);
      if (acc) w = w + 1;
    end
    for (int i = 0; i < 4; i++)
      cyc(0, 0, 0, 1, 1, 0, acc);

    // Back-to-back stream to A
    w = 32'h10;
    for (int i = 0; i < 40 && w <= 32'h1F; i++) begin
      cyc(1, 1, w, 1, 1, 0, acc);
      if (acc) w = w + 1;
    end
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 0, 1, 1, 0, acc);

    // Reset with both ports holding words
    cyc(1, 1, 32'h5A5A_0001, 0, 0, 0, acc);
    cyc(1, 0, 32'h5A5A_0002, 0, 0, 0, acc);
    cyc(1, 1, 32'h5A5A_0003, 0, 0, 0, acc);
    cyc(1, 0, 32'h5A5A_0004, 1, 1, 1, acc);
    cyc(1, 0, 32'h0000_0077, 1, 1, 0, acc);
    cyc(1, 1, 32'h0000_0066, 1, 1, 0, acc);
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 0, 1, 1, 0, acc);

    // Random traffic with rare resets
    words = 0;
    ncyc  = 0;
    while (words < 10000 && ncyc < 60000) begin
      cyc($urandom_range(0, 4) != 0,
          $urandom_range(0, 1) == 1,
          $urandom,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 2) != 0,
          $urandom_range(0, 2999) == 0,
          acc);
      if (acc) words++;
      ncyc++;
    end
    checks++;
    if (words < 10000) begin
      errors++;
      $display("FAIL rand_words: got %0d expected 10000", words);
    end

    for (int i = 0; i < 6; i++)
      cyc(0, 0, 0, 1, 1, 0, acc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
